// File: rtl/text_fetch.sv
// text_fetch: text-mode front end of the video path.
// Converts display-enable/frame timing into character-cell fetches:
//   VRAM char code -> chargen glyph row -> 8 serialised pixels as 4:4:4 RGB,
// with the pixel stream trailing 'active' by exactly 8 pixel clocks.
module text_fetch #(
  parameter int          COLS      = 128,
  parameter int          ROWS      = 96,
  parameter int          CHAR_H    = 8,
  parameter logic [15:0] VRAM_BASE = 16'h0000,
  parameter logic [11:0] FG        = 12'hFFF,
  parameter logic [11:0] BG        = 12'h000
) (
  input  logic        pix_clk_i,
  input  logic        reset_i,
  input  logic        frame_start_i,
  input  logic        active_i,
  output logic [15:0] vram_addr_o,
  input  logic [7:0]  vram_data_i,
  output logic [11:0] char_addr_o,
  input  logic [7:0]  char_data_i,
  output logic        rgb_valid_o,
  output logic        pix_on_o,
  output logic [3:0]  r_o,
  output logic [3:0]  g_o,
  output logic [3:0]  b_o
);

  // col saturates at COLS, text_row reaches ROWS, so both need one extra code
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = (ROWS < 2) ? 1 : $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HBLK = 2'd1,
    S_RUN  = 2'd2,
    S_OFF  = 2'd3
  } state_t;

  state_t        state_q;
  logic [2:0]    px_q;
  logic [CW-1:0] col_q;
  logic [3:0]    grow_q;
  logic [RW-1:0] trow_q;

  // fetch pipeline: cell issued (vld) and cell actually fetched (fet) per stage
  logic          vld_p0_q, vld_p1_q, vld_p2_q;
  logic          fet_p0_q, fet_p1_q, fet_p2_q;
  logic [15:0]   vram_addr_q;
  logic [15:0]   vram_addr_d;
  logic [11:0]   char_addr_q;
  logic [7:0]    glyph_p3_q;

  // output side: active delayed 8 cycles, local pixel index, glyph shifter
  logic [7:0]    vld_dly_q;
  logic [2:0]    opx_q;
  logic [7:0]    shift_q;

  logic          live;
  logic          cell_start;
  logic          fetch_start;
  logic          col_in_range;
  logic          grow_last;
  logic          trow_last;

  // A visible pixel only counts once a frame_start has armed the FSM.
  assign live         = (state_q != S_IDLE) && active_i;
  assign cell_start   = live && (px_q == 3'd0);
  assign col_in_range = (col_q < CW'(COLS));
  // Cells past the last column, and everything below the last text row, are blank.
  assign fetch_start  = cell_start && (state_q != S_OFF) && col_in_range;
  assign grow_last    = (grow_q == 4'(CHAR_H - 1));
  assign trow_last    = (trow_q == RW'(ROWS - 1));

  // Linear cell address; 16-bit wrap is intentional.
  assign vram_addr_d  = VRAM_BASE + (16'(trow_q) * 16'(COLS)) + 16'(col_q);

  // Line/frame sequencing and the input-side character counters.
  always_ff @(posedge pix_clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      px_q    <= 3'd0;
      col_q   <= '0;
      grow_q  <= 4'd0;
      trow_q  <= '0;
    end else if (frame_start_i) begin
      state_q <= S_HBLK;
      px_q    <= 3'd0;
      col_q   <= '0;
      grow_q  <= 4'd0;
      trow_q  <= '0;
    end else if (state_q != S_IDLE) begin
      if (active_i) begin
        px_q <= px_q + 3'd1;
        if ((px_q == 3'd7) && col_in_range) begin
          col_q <= col_q + CW'(1);
        end
        if (state_q == S_HBLK) begin
          state_q <= S_RUN;
        end
      end else begin
        // end of line (or idle blanking): a partial cell is simply dropped
        px_q  <= 3'd0;
        col_q <= '0;
        if (state_q == S_RUN) begin
          if (grow_last) begin
            grow_q  <= 4'd0;
            trow_q  <= trow_q + RW'(1);
            state_q <= trow_last ? S_OFF : S_HBLK;
          end else begin
            grow_q  <= grow_q + 4'd1;
            state_q <= S_HBLK;
          end
        end
      end
    end
  end

  // Fetch control: E0 issues the VRAM address, E2 forms the chargen address.
  always_ff @(posedge pix_clk_i) begin
    if (reset_i) begin
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      fet_p0_q    <= 1'b0;
      fet_p1_q    <= 1'b0;
      fet_p2_q    <= 1'b0;
      vram_addr_q <= 16'h0000;
      char_addr_q <= 12'h000;
    end else begin
      vld_p0_q <= cell_start;
      fet_p0_q <= fetch_start;
      vld_p1_q <= vld_p0_q;
      fet_p1_q <= fet_p0_q;
      vld_p2_q <= vld_p1_q;
      fet_p2_q <= fet_p1_q;
      if (fetch_start) begin
        vram_addr_q <= vram_addr_d;
      end
      // VRAM read data is valid two edges after the address was issued
      if (fet_p1_q) begin
        char_addr_q <= {vram_data_i, grow_q};
      end
    end
  end

  // Glyph capture at E3; blank cells hold an all-clear row so they show BG.
  always_ff @(posedge pix_clk_i) begin
    if (vld_p2_q) begin
      glyph_p3_q <= fet_p2_q ? char_data_i : 8'h00;
    end
  end

  // Output timing: 8-deep active delay and pixel index within the delayed cell.
  always_ff @(posedge pix_clk_i) begin
    if (reset_i) begin
      vld_dly_q <= 8'h00;
      opx_q     <= 3'd0;
    end else begin
      vld_dly_q <= {vld_dly_q[6:0], live};
      opx_q     <= vld_dly_q[6] ? (opx_q + 3'd1) : 3'd0;
    end
  end

  // Pixel serialiser: load on the first pixel of a delayed cell, then shift MSB-first.
  always_ff @(posedge pix_clk_i) begin
    if (vld_dly_q[6]) begin
      shift_q <= (opx_q == 3'd0) ? glyph_p3_q : {shift_q[6:0], 1'b0};
    end
  end

  assign vram_addr_o       = vram_addr_q;
  assign char_addr_o       = char_addr_q;
  assign rgb_valid_o       = vld_dly_q[7];
  assign pix_on_o          = vld_dly_q[7] & shift_q[7];
  assign {r_o, g_o, b_o}   = vld_dly_q[7] ? (shift_q[7] ? FG : BG) : 12'h000;

endmodule

// File: tb/tb_text_fetch.sv
// tb_text_fetch: directed bench for text_fetch with a per-cycle pixel scoreboard.
module tb_text_fetch;

  localparam int COLS   = 128;
  localparam int ROWS   = 2;
  localparam int CHAR_H = 8;
  localparam int HN     = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        active;
  logic [15:0] vram_addr;
  logic [7:0]  vram_data;
  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic        rgb_valid;
  logic        pix_on;
  logic [3:0]  r, g, b;

  always #5 clk = ~clk;

  text_fetch #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H),
    .VRAM_BASE(16'h0000), .FG(12'hFFF), .BG(12'h000)
  ) dut (
    .pix_clk_i(clk), .reset_i(reset), .frame_start_i(frame_start), .active_i(active),
    .vram_addr_o(vram_addr), .vram_data_i(vram_data),
    .char_addr_o(char_addr), .char_data_i(char_data),
    .rgb_valid_o(rgb_valid), .pix_on_o(pix_on),
    .r_o(r), .g_o(g), .b_o(b)
  );

  logic [7:0] vram [0:1023];

  function automatic logic [7:0] cgen(input logic [7:0] code, input logic [3:0] row);
    if (code == 8'h41 && row == 4'd0) return 8'b0001_1000;
    return (code * 8'd37) ^ {row, row ^ 4'h5};
  endfunction

  assign char_data = cgen(char_addr[11:4], char_addr[3:0]);

  always @(posedge clk) vram_data <= vram[vram_addr[9:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit sb_en   = 1'b0;

  logic [13:0] sbq [$];

  logic [15:0] h_vaddr [0:HN-1];
  logic [11:0] h_caddr [0:HN-1];
  logic        h_valid [0:HN-1];
  logic        h_pix   [0:HN-1];
  logic [11:0] h_rgb   [0:HN-1];

  // reference model state: line/pixel position since frame_start
  bit m_on   = 1'b0;
  bit m_prev = 1'b0;
  int m_line = 0;
  int m_x    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] model_out(input bit act);
    int trow, grow, col;
    logic [15:0] a;
    logic [7:0] gl;
    logic pb;
    if (!(act && m_on)) return 14'h0000;
    trow = m_line / CHAR_H;
    grow = m_line % CHAR_H;
    col  = m_x / 8;
    pb   = 1'b0;
    if (trow < ROWS && col < COLS) begin
      a  = 16'(trow * COLS + col);
      gl = cgen(vram[a[9:0]], 4'(grow));
      pb = gl[7 - (m_x % 8)];
    end
    return {1'b1, pb, (pb ? 12'hFFF : 12'h000)};
  endfunction

  task automatic step(input bit act, input bit fs, input bit rst);
    logic [13:0] obs, exp;
    @(negedge clk);
    if (cyc < HN) begin
      h_vaddr[cyc] = vram_addr;
      h_caddr[cyc] = char_addr;
      h_valid[cyc] = rgb_valid;
      h_pix[cyc]   = pix_on;
      h_rgb[cyc]   = {r, g, b};
    end
    obs = {rgb_valid, pix_on, r, g, b};
    if (sb_en && sbq.size() > 0) begin
      exp = sbq.pop_front();
      chk($sformatf("pixel@%0d", cyc), 32'(obs), 32'(exp));
    end
    active      = act;
    frame_start = fs;
    reset       = rst;
    if (rst) begin
      sbq.delete();
      repeat (8) sbq.push_back(14'h0000);
      m_on = 1'b0;
    end else begin
      sbq.push_back(model_out(act));
      if (fs) begin
        m_on = 1'b1; m_line = 0; m_x = 0;
      end else if (act) begin
        m_x++;
      end else if (m_prev) begin
        m_line++; m_x = 0;
      end
    end
    m_prev = act;
    cyc++;
  endtask

  task automatic run_line(input int n, input int gap, output int start);
    start = cyc;
    repeat (n) step(1'b1, 1'b0, 1'b0);
    repeat (gap) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int c, c0, c17, rr, chg;
    int rs[6];
    int rn[6];
    logic [7:0] pat;
    pat = 8'b0001_1000;
    reset = 1'b1; active = 1'b0; frame_start = 1'b0;
    for (int i = 0; i < 1024; i++) vram[i] = 8'(i * 29 + 11);
    vram[0] = 8'h41;

    repeat (3) step(1'b0, 1'b0, 1'b1);
    sb_en = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0);
    chk("rst_vaddr", 32'(h_vaddr[cyc-1]), 32'h0);
    chk("rst_caddr", 32'(h_caddr[cyc-1]), 32'h0);
    chk("rst_valid", 32'(h_valid[cyc-1]), 32'h0);
    chk("rst_pix",   32'(h_pix[cyc-1]),   32'h0);
    chk("rst_rgb",   32'(h_rgb[cyc-1]),   32'h0);

    // single cell 'A' on line 0
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    run_line(8, 10, c0);
    chk("cell_vaddr_E0", 32'(h_vaddr[c0+1]), 32'h0);
    chk("cell_caddr_E2", 32'(h_caddr[c0+3]), 32'h410);
    chk("cell_valid_E7", 32'(h_valid[c0+7]), 32'h0);
    chk("cell_valid_E8", 32'(h_valid[c0+8]), 32'h1);
    chk("cell_valid_E15", 32'(h_valid[c0+15]), 32'h1);
    chk("cell_valid_E16", 32'(h_valid[c0+16]), 32'h0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("cell_pix%0d", i), 32'(h_pix[c0+8+i]), 32'(pat[7-i]));
    chk("cell_rgb_set", 32'(h_rgb[c0+11]), 32'hFFF);
    chk("cell_rgb_clr", 32'(h_rgb[c0+8]),  32'h000);

    // second line: glyph row 1
    run_line(16, 4, c);
    chk("line2_caddr", 32'(h_caddr[c+3]), 32'h411);
    for (int l = 2; l < 8; l++) run_line(16, 4, c);
    // ninth line: text row 1, glyph row 0
    run_line(16, 4, c);
    chk("row1_vaddr", 32'(h_vaddr[c+1]), 32'd128);
    chk("row1_caddr_lo", 32'(h_caddr[c+3][3:0]), 32'h0);
    chk("row1_caddr", 32'(h_caddr[c+3]), 32'({vram[128], 4'h0}));
    for (int l = 9; l < 16; l++) run_line(16, 4, c);

    // lines 17..20 are past ROWS: BG, no new fetches
    run_line(16, 4, c17);
    for (int l = 17; l < 20; l++) run_line(16, 4, c);
    chk("off_vaddr_start", 32'(h_vaddr[c17+2]), 32'd129);
    chk("off_vaddr_end",   32'(h_vaddr[cyc-1]), 32'd129);
    chk("off_valid", 32'(h_valid[c17+8]), 32'h1);
    chk("off_rgb",   32'(h_rgb[c17+9]),   32'h000);

    // new frame, column overflow line
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    run_line(1040, 20, c);
    chk("frame_vaddr", 32'(h_vaddr[c+1]), 32'h0);
    chk("col127_vaddr", 32'(h_vaddr[c+1017]), 32'd127);
    chk("ovf_vaddr_end", 32'(h_vaddr[cyc-1]), 32'd127);
    chg = 0;
    for (int k = c + 2; k <= c + 1041; k++) if (h_vaddr[k] != h_vaddr[k-1]) chg++;
    chk("ovf_fetches", 32'(chg), 32'd127);
    for (int i = 1024; i < 1040; i++) begin
      chk($sformatf("ovf_valid%0d", i), 32'(h_valid[c+8+i]), 32'h1);
      chk($sformatf("ovf_rgb%0d", i),   32'(h_rgb[c+8+i]),   32'h000);
    end

    // random line lengths, multiples of 8
    for (int k = 0; k < 6; k++) begin
      rn[k] = 8 * int'($urandom_range(1, 8));
      run_line(rn[k], int'($urandom_range(2, 6)), rs[k]);
    end
    repeat (12) step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("drain_last%0d", k), 32'(h_valid[rs[k]+rn[k]+7]), 32'h1);
      chk($sformatf("drain_end%0d", k),  32'(h_valid[rs[k]+rn[k]+8]), 32'h0);
    end

    // reset mid-line
    repeat (12) step(1'b1, 1'b0, 1'b0);
    rr = cyc;
    repeat (5) step(1'b1, 1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    chk("mrst_vaddr", 32'(h_vaddr[rr+1]), 32'h0);
    chk("mrst_caddr", 32'(h_caddr[rr+1]), 32'h0);
    chk("mrst_valid", 32'(h_valid[rr+1]), 32'h0);
    chk("mrst_pix",   32'(h_pix[rr+1]),   32'h0);
    chk("mrst_rgb",   32'(h_rgb[rr+1]),   32'h0);
    run_line(16, 10, c);
    chk("idle_no_valid", 32'(h_valid[c+8]), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    run_line(16, 10, c);
    chk("resume_valid", 32'(h_valid[c+8]), 32'h1);
    chk("resume_caddr", 32'(h_caddr[c+3]), 32'h410);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
